// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake states and the machine word.
// Also holds the default value returned on a failed memory access.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  localparam word_t MEM_ERR_WORD = 32'hBAD1BAD1;

endpackage

// File: rtl/memory_arbiter_starve_counter.sv
// Saturating count of data grants made while an instruction fetch waits.
// limit tells the arbiter to force the next grant to the fetch side.
module starve_counter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic CLK,
  input  logic nRST,
  input  logic inc,
  input  logic clr,
  output logic limit
);

  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  logic [3:0] count;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && count != LIM) begin
      count <= count + 4'd1;
    end
  end

  assign limit = (count == LIM);

endmodule

// File: rtl/memory_arbiter.sv
// Serialises the merged instruction/data port onto one RAM port.
// Data wins ties; the starve counter forces a fetch through periodically.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int    STARVE_LIMIT = 4,
  parameter word_t ERR_WORD     = MEM_ERR_WORD
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      iwait,
  output word_t     iload,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      err
);

  typedef enum logic [1:0] {
    IDLE,
    DSERVE,
    ISERVE
  } arb_state_t;

  arb_state_t state, nextState;

  logic cntInc, cntClr, forceI;
  logic setErr, done, isErr;

  assign done  = (ramstate == ACCESS) || (ramstate == ERROR);
  assign isErr = (ramstate == ERROR);

  starve_counter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (cntInc),
    .clr  (cntClr),
    .limit(forceI)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      err   <= 1'b0;
    end else begin
      state <= nextState;
      if (setErr) err <= 1'b1;
    end
  end

  always_comb begin
    nextState = state;
    iwait     = 1'b1;
    dwait     = 1'b1;
    iload     = '0;
    dload     = '0;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    cntInc    = 1'b0;
    cntClr    = 1'b0;
    setErr    = 1'b0;
    unique case (state)
      IDLE: begin
        cntClr = !iREN;
        if ((dREN || dWEN) && !(iREN && forceI)) begin
          nextState = DSERVE;
        end else if (iREN) begin
          nextState = ISERVE;
        end
      end
      DSERVE: begin
        if (!(dREN || dWEN)) begin
          nextState = IDLE;
        end else begin
          ramaddr  = daddr;
          ramstore = dstore;
          ramWEN   = dWEN;
          ramREN   = !dWEN;
          if (done) begin
            dwait     = 1'b0;
            dload     = isErr ? ERR_WORD
                      : (dWEN ? '0 : ramload);
            setErr    = isErr;
            cntInc    = iREN;
            nextState = IDLE;
          end
        end
      end
      ISERVE: begin
        if (!iREN) begin
          nextState = IDLE;
        end else begin
          ramaddr = iaddr;
          ramREN  = 1'b1;
          if (done) begin
            iwait     = 1'b0;
            iload     = isErr ? ERR_WORD : ramload;
            setErr    = isErr;
            cntClr    = 1'b1;
            nextState = IDLE;
          end
        end
      end
      default: nextState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: vector table, corner sequences,
// and randomized traffic against a transaction-level model.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam int    LIM  = 4;
  localparam word_t ERRW = 32'hBAD1BAD1;

  typedef logic [132:0] outv_t;

  typedef struct {
    logic      iREN;
    logic      dREN;
    logic      dWEN;
    word_t     iaddr;
    word_t     daddr;
    word_t     dstore;
    word_t     ramload;
    ramstate_t rs;
    outv_t     exp;
  } vec_t;

  logic      CLK = 1'b0;
  logic      nRST;
  logic      iREN, dREN, dWEN;
  word_t     iaddr, daddr, dstore;
  logic      iwait, dwait;
  word_t     iload, dload;
  logic      ramREN, ramWEN;
  word_t     ramaddr, ramstore, ramload;
  ramstate_t ramstate;
  logic      err;

  int nCmp = 0;
  int nFail = 0;

  int mOwner, mStarve;
  bit mErr;
  outv_t cap;

  memory_arbiter dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .iREN    (iREN),
    .iaddr   (iaddr),
    .dREN    (dREN),
    .dWEN    (dWEN),
    .daddr   (daddr),
    .dstore  (dstore),
    .iwait   (iwait),
    .iload   (iload),
    .dwait   (dwait),
    .dload   (dload),
    .ramREN  (ramREN),
    .ramWEN  (ramWEN),
    .ramaddr (ramaddr),
    .ramstore(ramstore),
    .ramload (ramload),
    .ramstate(ramstate),
    .err     (err)
  );

  always #5 CLK = ~CLK;

  function automatic outv_t mk(
    logic iw, logic dw, logic rr, logic rw, logic er,
    word_t il, word_t dl, word_t ra, word_t rs
  );
    return {iw, dw, rr, rw, er, il, dl, ra, rs};
  endfunction

  function automatic outv_t curOut();
    return {iwait, dwait, ramREN, ramWEN, err,
            iload, dload, ramaddr, ramstore};
  endfunction

  task automatic chk(string name, outv_t act, outv_t exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Transaction view: who owns the RAM, how many data grants
  // have gone by while a fetch waited, and the sticky error.
  task automatic modelEval(
    output outv_t e, output int nO, output int nS, output bit nE
  );
    logic  iw, dw, rr, rw;
    word_t il, dl, ra, rs;
    bit    fin, bad;
    iw = 1; dw = 1; rr = 0; rw = 0;
    il = 0; dl = 0; ra = 0; rs = 0;
    nO = mOwner; nS = mStarve; nE = mErr;
    fin = (ramstate == ACCESS) || (ramstate == ERROR);
    bad = (ramstate == ERROR);
    if (!nRST) begin
      nO = 0; nS = 0; nE = 0;
      e = mk(1, 1, 0, 0, 0, 0, 0, 0, 0);
      return;
    end
    if (mOwner == 0) begin
      if (!iREN) nS = 0;
      if ((dREN || dWEN) && !(iREN && mStarve == LIM)) nO = 1;
      else if (iREN) nO = 2;
    end else if (mOwner == 1) begin
      if (!(dREN || dWEN)) nO = 0;
      else begin
        ra = daddr; rs = dstore;
        rw = dWEN; rr = !dWEN;
        if (fin) begin
          dw = 0;
          dl = bad ? ERRW : (dWEN ? 32'h0 : ramload);
          nO = 0;
          if (bad) nE = 1;
          if (iREN) nS = (mStarve + 1 > LIM) ? LIM : mStarve + 1;
        end
      end
    end else begin
      if (!iREN) nO = 0;
      else begin
        ra = iaddr; rr = 1;
        if (fin) begin
          iw = 0;
          il = bad ? ERRW : ramload;
          nO = 0; nS = 0;
          if (bad) nE = 1;
        end
      end
    end
    e = mk(iw, dw, rr, rw, mErr, il, dl, ra, rs);
  endtask

  task automatic step();
    outv_t e;
    int nO, nS;
    bit nE;
    @(negedge CLK);
    modelEval(e, nO, nS, nE);
    cap = curOut();
    chk("model", cap, e);
    @(posedge CLK);
    mOwner = nO; mStarve = nS; mErr = nE;
    #1;
  endtask

  task automatic idleIn();
    iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0;
    ramload = 0; ramstate = FREE;
  endtask

  task automatic doReset();
    nRST = 0;
    step();
    chk("reset", cap, mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
    nRST = 1;
  endtask

  vec_t vt[12];
  string seq;
  int nI;

  initial begin
    mOwner = 0; mStarve = 0; mErr = 0;
    idleIn();
    doReset();

    vt[0]  = '{0, 1, 0, 0, 32'h40, 0, 0, FREE,
               mk(1, 1, 0, 0, 0, 0, 0, 0, 0)};
    vt[1]  = '{0, 1, 0, 0, 32'h40, 0, 32'hDEADBEEF, ACCESS,
               mk(1, 0, 1, 0, 0, 0, 32'hDEADBEEF, 32'h40, 0)};
    vt[2]  = '{0, 0, 0, 0, 0, 0, 0, FREE,
               mk(1, 1, 0, 0, 0, 0, 0, 0, 0)};
    vt[3]  = '{0, 0, 1, 0, 32'h80, 32'h1234, 0, BUSY,
               mk(1, 1, 0, 0, 0, 0, 0, 0, 0)};
    vt[4]  = '{0, 0, 1, 0, 32'h80, 32'h1234, 0, BUSY,
               mk(1, 1, 0, 1, 0, 0, 0, 32'h80, 32'h1234)};
    vt[5]  = vt[4];
    vt[6]  = vt[4];
    vt[7]  = '{0, 0, 1, 0, 32'h80, 32'h1234, 32'h55, ACCESS,
               mk(1, 0, 0, 1, 0, 0, 0, 32'h80, 32'h1234)};
    vt[8]  = vt[2];
    vt[9]  = '{1, 0, 0, 32'h100, 0, 0, 0, FREE,
               mk(1, 1, 0, 0, 0, 0, 0, 0, 0)};
    vt[10] = '{1, 0, 0, 32'h100, 0, 0, 32'hCAFE, ACCESS,
               mk(0, 1, 1, 0, 0, 32'hCAFE, 0, 32'h100, 0)};
    vt[11] = vt[2];

    foreach (vt[k]) begin
      iREN = vt[k].iREN; dREN = vt[k].dREN; dWEN = vt[k].dWEN;
      iaddr = vt[k].iaddr; daddr = vt[k].daddr;
      dstore = vt[k].dstore; ramload = vt[k].ramload;
      ramstate = vt[k].rs;
      step();
      chk($sformatf("vec%0d", k), cap, vt[k].exp);
    end

    // simultaneous requests: data first, fetch after one idle cycle
    idleIn();
    doReset();
    iREN = 1; dREN = 1; iaddr = 32'h200; daddr = 32'h300;
    ramstate = ACCESS; ramload = 32'h1111;
    nI = 0;
    step(); nI += !cap[132];
    step(); nI += !cap[132];
    chk("sim_d_first", {cap[132], cap[131]}, 2'b10);
    dREN = 0;
    step(); nI += !cap[132];
    chk("sim_gap", {cap[132], cap[131], cap[130]}, 3'b110);
    step(); nI += !cap[132];
    chk("sim_i_done", cap[132], 1'b0);
    iREN = 0;
    step(); nI += !cap[132];
    chk("sim_i_once", 133'(nI), 133'(1));

    // starvation: fetch forced after LIM back-to-back data grants
    idleIn();
    doReset();
    iREN = 1; dREN = 1; iaddr = 32'h200; daddr = 32'h300;
    ramstate = ACCESS; ramload = 32'h2222;
    seq = "";
    for (int c = 0; c < 30; c++) begin
      step();
      if (!cap[131]) seq = {seq, "D"};
      if (!cap[132]) seq = {seq, "I"};
    end
    nCmp++;
    if (seq.substr(0, 9) != "DDDDIDDDDI") begin
      nFail++;
      $display("FAIL starve_order: got %s want DDDDIDDDDI...", seq);
    end
    idleIn();
    step();

    // abort: data request dropped while RAM busy
    dREN = 1; daddr = 32'h44; ramstate = BUSY;
    step();
    step();
    chk("abort_pre", {cap[131], cap[130]}, 2'b11);
    dREN = 0;
    step();
    chk("abort_cyc", {cap[131], cap[130]}, 2'b10);
    dREN = 1; ramstate = ACCESS; ramload = 32'h3333;
    step();
    chk("abort_idle", {cap[131], cap[130]}, 2'b10);
    step();
    chk("abort_redo", {cap[131], cap[130]}, 2'b01);
    idleIn();
    step();

    // error on a fetch: error word returned, err sticky
    iREN = 1; iaddr = 32'h500; ramstate = ERROR;
    step();
    step();
    chk("ierr_word", {cap[132], cap[128], cap[127:96]},
        {1'b0, 1'b0, ERRW});
    idleIn();
    step();
    chk("err_set", cap[128], 1'b1);
    step();
    step();
    chk("err_sticky", cap[128], 1'b1);

    // reset in the middle of a busy fetch
    iREN = 1; iaddr = 32'h600; ramstate = BUSY;
    step();
    step();
    chk("rst_pre", cap[130], 1'b1);
    nRST = 0;
    #1;
    chk("rst_async", curOut(), mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
    step();
    nRST = 1;
    ramstate = ACCESS; ramload = 32'h77;
    step();
    step();
    chk("rst_refetch", {cap[132], cap[127:96]}, {1'b0, 32'h77});
    idleIn();
    step();

    // randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      nRST = ($urandom_range(0, 99) != 0);
      iREN = ($urandom_range(0, 3) != 0);
      dREN = ($urandom_range(0, 2) == 0);
      dWEN = ($urandom_range(0, 3) == 0);
      iaddr = $urandom; daddr = $urandom;
      dstore = $urandom; ramload = $urandom;
      ramstate = ramstate_t'($urandom_range(0, 3));
      step();
    end
    nRST = 1;
    idleIn();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCmp, nFail);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Downstream of the coherence controller. Consumes its single merged memory port: one instruction request and one data read/write request.
- Serialises those requests onto one single-ported RAM interface.
- Data requests take priority over instruction requests. A starvation counter guarantees that instruction fetches still make progress.
- Returns wait/load handshakes to the coherence controller.

Parameters:
- STARVE_LIMIT, 4: number of consecutive data grants allowed while iREN is pending before one instruction grant is forced. Legal range 1..15.
- ERR_WORD, 32'hBAD1BAD1: value placed on iload/dload when the RAM reports ERROR.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- iREN  in  1  instruction read request.
- iaddr  in  32  instruction word address.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  32  data word address.
- dstore  in  32  data write value.
- iwait  out  1  low for exactly one cycle when the instruction access completes.
- iload  out  32  instruction data, valid while iwait=0.
- dwait  out  1  low for exactly one cycle when the data access completes.
- dload  out  32  read data, valid while dwait=0.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR.
- err  out  1  sticky; set on any ERROR response.

Behaviour:
- Reset values (asynchronous, on nRST low):
  - state=IDLE, starve counter=0, err=0.
  - iwait=1, dwait=1, iload=0, dload=0.
  - ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
- States: IDLE, DSERVE, ISERVE.
- IDLE:
  - RAM strobes are 0.
  - If (dREN|dWEN) and not forced-instruction, go to DSERVE.
  - Otherwise, if iREN, go to ISERVE.
  - Otherwise stay in IDLE.
  - Forced-instruction means iREN=1 and starve counter == STARVE_LIMIT.
- DSERVE:
  - ramaddr=daddr, ramstore=dstore.
  - dWEN=1 drives ramWEN=1, ramREN=0. If dREN and dWEN are both 1, the write wins.
  - Otherwise ramREN=1.
  - On ramstate==ACCESS, combinationally drive dwait=0 and dload=ramload (dload=0 for writes), then go to IDLE.
  - On ramstate==ERROR, drive dwait=0, dload=ERR_WORD, set err, then go to IDLE.
  - On FREE/BUSY, stay in DSERVE.
- ISERVE:
  - ramREN=1, ramaddr=iaddr.
  - Completion is identical to DSERVE but uses iwait/iload.
  - Instruction accesses never write.
- Abort: if the granted request drops (dREN=dWEN=0 in DSERVE, or iREN=0 in ISERVE) before completion:
  - RAM strobes are 0 that cycle.
  - wait stays 1.
  - Next state is IDLE.
  - No completion pulse is produced.
- Starve counter:
  - Increments on each DSERVE completion when iREN=1.
  - Saturates at STARVE_LIMIT.
  - Clears on any ISERVE completion, or whenever iREN=0 in IDLE.
- Latency:
  - The request is seen in IDLE at cycle N; the RAM is driven from N+1.
  - With RAM ACCESS on first drive, wait is low at N+1 and the arbiter is back in IDLE at N+2.
  - Every grant has a minimum one-cycle IDLE gap, which allows the requester to deassert or re-address.
- The non-granted side always sees wait=1 and load=0.
- Address and store values are not latched. The requester holds them stable until its wait goes low, which the coherence controller guarantees.
- Reset mid-transaction: immediate return to reset values. No partial completion pulse is produced.

Decomposition:
- ramstate_t and word_t come from cpu_types_pkg. No new package types.
- arb_state_t (IDLE/DSERVE/ISERVE) is local to the module.
- Add MEM_ERR_WORD to cpu_types_pkg as the default for ERR_WORD.
- One natural sub-module, starve_counter: a saturating counter with inc/clr/limit-reached outputs, parameterised by STARVE_LIMIT.

Test Plan:
- Data read: dREN=1, daddr=0x40, RAM returns ACCESS on its first cycle with ramload=0xDEADBEEF -> ramREN=1, ramaddr=0x40 at N+1; dwait=0 and dload=0xDEADBEEF at N+1; IDLE at N+2.
- Data write with RAM BUSY for 3 cycles: dWEN=1, daddr=0x80, dstore=0x1234 -> ramWEN held for 4 cycles; dwait low only on the ACCESS cycle; iwait stays 1 throughout.
- Simultaneous iREN and dREN at IDLE -> DSERVE first; then ISERVE after one IDLE cycle; iwait low exactly once.
- Starvation: iREN held, data requests issued back-to-back, STARVE_LIMIT=4 -> 4 data completions, then one instruction completion, then the counter returns to 0.
- Abort and error:
  - dREN dropped in DSERVE while BUSY -> no dwait pulse; IDLE next cycle.
  - ramstate=ERROR on an iREN access -> iwait=0, iload=0xBAD1BAD1, err=1 and staying 1.
- Reset asserted during ISERVE with BUSY -> all outputs at reset values immediately; the post-reset iREN is re-serviced normally.
